// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx between NUM_REQ byte streams.
// Optional stall watchdog: define UART_ARB_TIMEOUT_EN to force-release a stalled owner.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [8*NUM_REQ-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]   i_req_last,
    output logic [NUM_REQ-1:0]   o_req_ready,
    output logic                 o_tx_start,
    output logic [7:0]           o_tx_data,
    input  logic                 i_tx_busy,
    output logic                 o_busy,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] o_owner,
    output logic                 o_timeout
);

    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {IDLE, ACCEPT, SEND, GUARD, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [OW-1:0] owner, last_owner, pick;
    logic          any_valid;
    logic          hs;
    logic          last_q;
    logic          to_hit;
    int            idx;

    // First valid requester searching upward from last_owner+1, wrapping.
    always_comb begin
        pick      = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(last_owner) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any_valid && i_req_valid[idx]) begin
                any_valid = 1'b1;
                pick      = OW'(idx);
            end
        end
    end

    always_comb begin
        o_req_ready = '0;
        if (state == ACCEPT && !i_tx_busy) o_req_ready[owner] = 1'b1;
    end

    assign hs = |(o_req_ready & i_req_valid);

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] stall_cnt;
    logic          timeout_q;

    // Any cycle outside ACCEPT clears the count, so every ACCEPT entry starts at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= to_hit;
            if (state != ACCEPT || hs) stall_cnt <= '0;
            else                       stall_cnt <= stall_cnt + CW'(1);
        end
    end

    assign to_hit    = (state == ACCEPT) && !hs && (stall_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign o_timeout = timeout_q;
`else
    assign to_hit    = 1'b0;
    // Constant 0 for any legal TIMEOUT_CYCLES; a misconfigured value shows as a stuck flag.
    assign o_timeout = (TIMEOUT_CYCLES < 2);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid) state_nxt = ACCEPT;
            ACCEPT:  begin
                if (hs)          state_nxt = SEND;
                else if (to_hit) state_nxt = IDLE;
            end
            SEND:    state_nxt = GUARD;
            GUARD:   state_nxt = DRAIN;
            DRAIN:   if (!i_tx_busy) state_nxt = last_q ? IDLE : ACCEPT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= OW'(NUM_REQ - 1);
            last_q     <= 1'b0;
            o_tx_data  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_valid) owner <= pick;
            if (hs) begin
                o_tx_data <= i_req_data[{owner, 3'b000} +: 8];
                last_q    <= i_req_last[owner];
            end
            if ((state == DRAIN && !i_tx_busy && last_q) || to_hit) last_owner <= owner;
        end
    end

    assign o_tx_start = (state == SEND);
    assign o_busy     = (state != IDLE);
    assign o_owner    = owner;

endmodule
